// File: rtl/requant_pkg.sv
// Shared widths, rounding-mode selector and helpers for the requantizer path.
package requant_pkg;

    localparam int unsigned DEF_N_REQ      = 4;
    localparam int unsigned DEF_NB_XI      = 17;
    localparam int unsigned DEF_NBF_XI     = 10;
    localparam int unsigned DEF_NB_XO      = 9;
    localparam int unsigned DEF_NBF_XO     = 7;
    localparam int unsigned DEF_NB_CNT     = 16;

    localparam int unsigned RND_TRUNC      = 0;
    localparam int unsigned RND_HALF_EVEN  = 1;
    localparam int unsigned DEF_ROUND_EVEN = RND_HALF_EVEN;

    // Ceiling log2, used to size requester indices.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_trunc.sv
// Combinational requantizer: align fractional bits, round (half-even or truncate), saturate.
module sat_trunc
    import requant_pkg::*;
#(
    parameter int unsigned NB_XI      = DEF_NB_XI,
    parameter int unsigned NBF_XI     = DEF_NBF_XI,
    parameter int unsigned NB_XO      = DEF_NB_XO,
    parameter int unsigned NBF_XO     = DEF_NBF_XO,
    parameter int unsigned ROUND_EVEN = DEF_ROUND_EVEN
) (
    input  logic [NB_XI-1:0] i_x,
    output logic [NB_XO-1:0] o_y_c,
    output logic             o_sat_c
);

    localparam int          SH    = int'(NBF_XI) - int'(NBF_XO);
    localparam int unsigned LS    = (SH < 0) ? unsigned'(-SH) : 0;
    localparam int unsigned WE    = NB_XI + LS + 1;
    localparam logic signed [WE-1:0] MAX_W = WE'(2**(NB_XO-1) - 1);
    localparam logic signed [WE-1:0] MIN_W = -MAX_W - WE'(1);
    localparam logic [NB_XO-1:0]     MAX_Y = NB_XO'(MAX_W);
    localparam logic [NB_XO-1:0]     MIN_Y = NB_XO'(MIN_W);

    logic signed [WE-1:0] w_r;

    generate
        if (SH > 0) begin : g_round
            localparam logic [SH-1:0] HALF = SH'(1) << (SH - 1);
            logic signed [NB_XI-1:0] w_q;
            logic [SH-1:0]           w_rem;
            logic                    w_inc;

            assign w_q   = $signed(i_x) >>> SH;
            assign w_rem = i_x[SH-1:0];
            // Ties go up only when that lands on an even quotient.
            assign w_inc = (ROUND_EVEN != 0) &&
                           ((w_rem > HALF) || ((w_rem == HALF) && w_q[0]));
            assign w_r   = WE'(w_q) + WE'(w_inc);
        end else begin : g_shift
            assign w_r = WE'($signed(i_x)) <<< LS;
        end
    endgenerate

    always_comb begin
        o_y_c = w_r[NB_XO-1:0];
        if (w_r > MAX_W)      o_y_c = MAX_Y;
        else if (w_r < MIN_W) o_y_c = MIN_Y;
    end

    // A result that lands exactly on a rail is reported as a clip code too.
    assign o_sat_c = (o_y_c == MAX_Y) || (o_y_c == MIN_Y);

endmodule

// File: rtl/requant_rr_arbiter.sv
// Round-robin arbiter feeding one shared requantizer with a single-entry output register.
module requant_rr_arbiter
    import requant_pkg::*;
#(
    parameter int unsigned N_REQ      = DEF_N_REQ,
    parameter int unsigned NB_XI      = DEF_NB_XI,
    parameter int unsigned NBF_XI     = DEF_NBF_XI,
    parameter int unsigned NB_XO      = DEF_NB_XO,
    parameter int unsigned NBF_XO     = DEF_NBF_XO,
    parameter int unsigned ROUND_EVEN = DEF_ROUND_EVEN,
    parameter int unsigned NB_CNT     = DEF_NB_CNT
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_valid,
    input  logic [N_REQ*NB_XI-1:0]    i_data,
    output logic [N_REQ-1:0]          o_ready,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [NB_XO-1:0]          o_data,
    output logic [clog2(N_REQ)-1:0]   o_src,
    output logic                      o_sat,
    input  logic                      i_clr_cnt,
    output logic [NB_CNT-1:0]         o_sat_cnt
);

    localparam int unsigned SW     = clog2(N_REQ);
    localparam logic [SW:0] NREQ_W = (SW+1)'(N_REQ);

    logic                 r_valid;
    logic [NB_XO-1:0]     r_data;
    logic [SW-1:0]        r_src;
    logic                 r_sat;
    logic [SW-1:0]        r_ptr;
    logic [NB_CNT-1:0]    r_cnt;

    logic                 w_can_load;
    logic                 w_any;
    logic                 w_xfer_in;
    logic [2*N_REQ-1:0]   w_dbl;
    logic [N_REQ-1:0]     w_rot;
    logic [SW-1:0]        w_off;
    logic [SW:0]          w_sum;
    logic [SW-1:0]        w_gnt;
    logic [SW:0]          w_inc;
    logic [SW-1:0]        w_ptr_nxt;
    logic [NB_XI-1:0]     w_word;
    logic [NB_XO-1:0]     w_y;
    logic                 w_y_sat;

    assign w_can_load = ~r_valid | i_ready;

    // Rotate so the pointer sits at bit 0, pick the lowest set bit, then unrotate.
    assign w_dbl = {i_valid, i_valid};
    assign w_rot = N_REQ'(w_dbl >> r_ptr);

    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int j = int'(N_REQ) - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_any = 1'b1;
                w_off = SW'(j);
            end
        end
    end

    assign w_sum     = (SW+1)'(r_ptr) + (SW+1)'(w_off);
    assign w_gnt     = (w_sum >= NREQ_W) ? SW'(w_sum - NREQ_W) : SW'(w_sum);
    assign w_inc     = (SW+1)'(w_gnt) + (SW+1)'(1);
    assign w_ptr_nxt = (w_inc == NREQ_W) ? '0 : SW'(w_inc);

    assign w_xfer_in = i_rst_n & w_any & w_can_load;
    assign o_ready   = {N_REQ{w_xfer_in}} & (N_REQ'(1) << w_gnt);
    assign w_word    = i_data[w_gnt*NB_XI +: NB_XI];

    sat_trunc #(
        .NB_XI      (NB_XI),
        .NBF_XI     (NBF_XI),
        .NB_XO      (NB_XO),
        .NBF_XO     (NBF_XO),
        .ROUND_EVEN (ROUND_EVEN)
    ) u_sat_trunc (
        .i_x     (w_word),
        .o_y_c   (w_y),
        .o_sat_c (w_y_sat)
    );

    // Output stage, pointer advance and saturating clip counter (clear wins).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
            r_sat   <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_xfer_in) begin
                r_valid <= 1'b1;
                r_data  <= w_y;
                r_src   <= w_gnt;
                r_sat   <= w_y_sat;
                r_ptr   <= w_ptr_nxt;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
            if (i_clr_cnt) begin
                r_cnt <= '0;
            end else if (w_xfer_in && w_y_sat && (r_cnt != '1)) begin
                r_cnt <= r_cnt + NB_CNT'(1);
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_src     = r_src;
    assign o_sat     = r_sat;
    assign o_sat_cnt = r_cnt;

endmodule
